// File: rtl/defs_pkg.sv
// Shared AXI read-channel widths and encodings for the instruction-memory slave.
package defs_pkg;

  localparam int unsigned AxiIdWidth = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/sram_1r1w.sv
// Single-clock memory with one synchronous read port and one write port.
// A read and write to the same word in one cycle returns the pre-write contents.
module sram_1r1w #(
  parameter int unsigned Words = 1024,
  parameter int unsigned Width = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Words)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(Words)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Words];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_imem_rd_slave.sv
// AXI4 read-only slave over a preloadable 64-bit instruction memory.
// One burst at a time; each beat takes an address cycle followed by a data cycle.
module axi_imem_rd_slave
  import defs_pkg::*;
#(
  parameter int unsigned MemWords = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AxiIdWidth-1:0]       axi_arid,
  input  logic [31:0]                 axi_araddr,
  input  logic [7:0]                  axi_arlen,
  input  logic [2:0]                  axi_arsize,
  input  logic [1:0]                  axi_arburst,
  input  logic                        axi_arlock,
  input  logic [3:0]                  axi_arcache,
  input  logic [2:0]                  axi_arprot,
  input  logic [3:0]                  axi_arqos,
  input  logic [3:0]                  axi_arregion,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  output logic [AxiIdWidth-1:0]       axi_rid,
  output logic [63:0]                 axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rlast,
  output logic                        axi_rvalid,
  input  logic                        axi_rready,
  input  logic                        load_we,
  input  logic [$clog2(MemWords)-1:0] load_idx,
  input  logic [63:0]                 load_data,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(MemWords);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  logic [AxiIdWidth-1:0] id_q;
  logic [31:0]           addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic                  rdata_ok;

  logic [31:0]           offset;
  logic                  in_range;
  logic [IdxW-1:0]       word_idx;
  logic [1:0]            beat_resp;
  logic                  rd_en;
  logic [63:0]           mem_rdata;

  // Per-beat decode of the current address; non-INCR/FIXED bursts always error.
  always_comb begin
    offset    = addr_q - BaseAddr;
    in_range  = (addr_q >= BaseAddr) && ((offset >> 3) < 32'(MemWords));
    word_idx  = offset[IdxW+2:3];
    beat_resp = RESP_OKAY;
    if ((burst_q != BURST_INCR) && (burst_q != BURST_FIXED)) beat_resp = RESP_SLVERR;
    else if (!in_range) beat_resp = RESP_DECERR;
    rd_en     = (state == ADDR) && (beat_resp == RESP_OKAY);
  end

  sram_1r1w #(
    .Words(MemWords),
    .Width(64)
  ) u_mem (
    .clk  (clk),
    .we   (load_we),
    .waddr(load_idx),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(word_idx),
    .rdata(mem_rdata)
  );

  // Error beats and reset present zero data without disturbing the read register.
  assign axi_rdata = rdata_ok ? mem_rdata : 64'h0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rid     <= '0;
      rdata_ok    <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= BURST_INCR;
    end else begin
      case (state)
        IDLE: begin
          if (axi_arvalid && axi_arready) begin
            id_q        <= axi_arid;
            addr_q      <= {axi_araddr[31:3], 3'b000};
            len_q       <= axi_arlen;
            burst_q     <= axi_arburst;
            cnt_q       <= '0;
            axi_arready <= 1'b0;
            state       <= ADDR;
          end else begin
            axi_arready <= 1'b1;
          end
        end
        ADDR: begin
          axi_rvalid <= 1'b1;
          axi_rresp  <= beat_resp;
          axi_rid    <= id_q;
          axi_rlast  <= (cnt_q == len_q);
          rdata_ok   <= (beat_resp == RESP_OKAY);
          state      <= DATA;
        end
        DATA: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            axi_rlast  <= 1'b0;
            if (axi_rlast) begin
              axi_arready <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
              if (burst_q == BURST_INCR) addr_q <= addr_q + 32'd8;
              state <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{axi_arsize, axi_arlock, axi_arcache, axi_arprot,
                           axi_arqos, axi_arregion, axi_araddr[2:0]};

endmodule

// File: tb/tb_axi_imem_rd_slave.sv
// Directed plus randomized read bursts against an address-arithmetic model of the memory map.
module tb_axi_imem_rd_slave;
  import defs_pkg::*;

  localparam int unsigned MemW = 1024;
  localparam int unsigned IdxW = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [AxiIdWidth-1:0] axi_arid;
  logic [31:0]           axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arlock;
  logic [3:0]            axi_arcache;
  logic [2:0]            axi_arprot;
  logic [3:0]            axi_arqos;
  logic [3:0]            axi_arregion;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [AxiIdWidth-1:0] axi_rid;
  logic [63:0]           axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic                  load_we;
  logic [IdxW-1:0]       load_idx;
  logic [63:0]           load_data;
  logic                  busy;

  logic [63:0] model_mem [MemW];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_imem_rd_slave #(.MemWords(MemW), .BaseAddr(32'h0)) dut (
    .clk(clk), .rst(rst),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
    .axi_arregion(axi_arregion), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat i of a burst, derived from the address map alone.
  task automatic model_beat(input logic [31:0] start, input logic [1:0] burst, input int i,
                            output logic [63:0] d, output logic [1:0] r);
    logic [31:0] a;
    a = {start[31:3], 3'b000};
    if (burst == BURST_INCR) a = a + 32'(8 * i);
    if (burst != BURST_INCR && burst != BURST_FIXED) begin
      d = 64'h0; r = RESP_SLVERR;
    end else if ((a / 8) >= MemW) begin
      d = 64'h0; r = RESP_DECERR;
    end else begin
      d = model_mem[a / 8]; r = RESP_OKAY;
    end
  endtask

  task automatic do_burst(input logic [AxiIdWidth-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int stall_beat, input int stall_n, input int abort_beat,
                          input bit same_wr, input logic [63:0] wr_data);
    logic [63:0] ed;
    logic [1:0]  er;
    int guard;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
    axi_arsize = 3'd3; axi_arvalid = 1'b1; axi_rready = 1'b1;
    guard = 0;
    while (!axi_arready && guard < 20) begin step; guard++; end
    check("ar_wait", 64'(guard < 20), 64'd1);
    step;
    axi_arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      check("gap_rvalid", 64'(axi_rvalid), 64'd0);
      check("busy_hi", 64'(busy), 64'd1);
      check("arready_busy", 64'(axi_arready), 64'd0);
      model_beat(addr, burst, i, ed, er);
      if (same_wr && i == 0) begin
        load_we = 1'b1; load_idx = addr[IdxW+2:3]; load_data = wr_data;
      end
      step;
      if (load_we) begin
        model_mem[load_idx] = load_data;
        load_we = 1'b0;
      end
      check("rvalid", 64'(axi_rvalid), 64'd1);
      check("rdata", axi_rdata, ed);
      check("rresp", 64'(axi_rresp), 64'(er));
      check("rlast", 64'(axi_rlast), 64'(i == int'(len)));
      check("rid", 64'(axi_rid), 64'(id));
      if (i == abort_beat) begin
        rst = 1'b1;
        #1;
        check("abort_rvalid", 64'(axi_rvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_arready", 64'(axi_arready), 64'd0);
        step;
        rst = 1'b0;
        step;
        check("arready_after_rst", 64'(axi_arready), 64'd1);
        return;
      end
      if (i == stall_beat) begin
        axi_rready = 1'b0;
        repeat (stall_n) begin
          step;
          check("stall_rvalid", 64'(axi_rvalid), 64'd1);
          check("stall_rdata", axi_rdata, ed);
          check("stall_rlast", 64'(axi_rlast), 64'(i == int'(len)));
        end
        axi_rready = 1'b1;
      end
      step;
    end
    check("end_rvalid", 64'(axi_rvalid), 64'd0);
    check("end_arready", 64'(axi_arready), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rb;
    int          sb;
    rst = 1'b1;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = BURST_INCR;
    axi_arlock = 1'b0; axi_arcache = '0; axi_arprot = '0; axi_arqos = '0; axi_arregion = '0;
    axi_arvalid = 1'b0; axi_rready = 1'b0;
    load_we = 1'b0; load_idx = '0; load_data = '0;
    step; step;
    check("rst_arready", 64'(axi_arready), 64'd0);
    check("rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("rst_rlast", 64'(axi_rlast), 64'd0);
    check("rst_rresp", 64'(axi_rresp), 64'd0);
    check("rst_rid", 64'(axi_rid), 64'd0);
    check("rst_rdata", axi_rdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step;
    check("arready_rise", 64'(axi_arready), 64'd1);

    // Backdoor preload of the whole memory.
    for (int w = 0; w < int'(MemW); w++) begin
      load_we = 1'b1;
      load_idx = IdxW'(w);
      load_data = (w < 4) ? 64'(17 * (w + 1)) : {$urandom, $urandom};
      model_mem[w] = load_data;
      step;
    end
    load_we = 1'b0;

    do_burst(4'd5, 32'h0, 8'd3, BURST_INCR, -1, 0, -1, 1'b0, 64'h0);
    do_burst(4'd1, 32'h10, 8'd2, BURST_FIXED, -1, 0, -1, 1'b0, 64'h0);
    do_burst(4'd2, 32'h1FF8, 8'd1, BURST_INCR, -1, 0, -1, 1'b0, 64'h0);
    do_burst(4'd3, 32'h40, 8'd3, BURST_WRAP, -1, 0, -1, 1'b0, 64'h0);
    do_burst(4'd6, 32'h20, 8'd3, BURST_INCR, 1, 5, -1, 1'b0, 64'h0);
    do_burst(4'd7, 32'h80, 8'd2, BURST_FIXED, -1, 0, -1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    do_burst(4'd8, 32'hFFFF_FFF8, 8'd1, BURST_INCR, -1, 0, -1, 1'b0, 64'h0);
    do_burst(4'd9, 32'h100, 8'd7, BURST_INCR, -1, 0, 2, 1'b0, 64'h0);
    do_burst(4'd10, 32'h100, 8'd1, BURST_INCR, -1, 0, -1, 1'b0, 64'h0);

    for (int n = 0; n < 12; n++) begin
      ra = 32'($urandom_range(0, 1040)) * 32'd8 + 32'($urandom_range(0, 7));
      rb = ($urandom_range(0, 5) == 0) ? BURST_WRAP :
           ($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_INCR;
      sb = ($urandom_range(0, 1) == 0) ? -1 : 0;
      do_burst(AxiIdWidth'($urandom), ra, 8'($urandom_range(0, 7)), rb,
               sb, $urandom_range(1, 4), -1, 1'b0, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
